// File: rtl/alu_dec_n.sv
// RV32I integer-compute decoder feeding alu_n through a registered output stage.
// Define ALU_DEC_SKID_EN for a two-entry (main + skid) stage with a registered inst_ready_o.
module alu_dec_n #(
  parameter int n = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   inst_i,
  input  logic          inst_valid_i,
  output logic          inst_ready_o,
  input  logic [n-1:0]  pc_i,
  output logic [4:0]    rs1_addr_o,
  output logic [4:0]    rs2_addr_o,
  input  logic [n-1:0]  rs1_data_i,
  input  logic [n-1:0]  rs2_data_i,
  output logic [n-1:0]  operand0_o,
  output logic [n-1:0]  operand1_o,
  output logic [3:0]    alu_op_o,
  output logic [4:0]    rd_addr_o,
  output logic          illegal_o,
  output logic          alu_valid_o,
  input  logic          alu_ready_i
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [3:0] OP_SRA    = 4'hd;

  typedef struct packed {
    logic [n-1:0] op0;
    logic [n-1:0] op1;
    logic [3:0]   op;
    logic [4:0]   rd;
    logic         ill;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  entry_t     dec;
  entry_t     main_q, main_d;
  logic       main_valid_q, main_valid_d;
  logic       accept;
  logic       drain;

  assign opcode     = inst_i[6:0];
  assign funct3     = inst_i[14:12];
  assign funct7     = inst_i[31:25];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  // Decode; sub/sra land on {1,funct3} so the alt-funct7 ops need no table.
  always_comb begin
    bad     = 1'b0;
    dec     = '0;
    dec.rd  = inst_i[11:7];
    case (opcode)
      OPC_OP: begin
        dec.op0 = rs1_data_i;
        dec.op1 = rs2_data_i;
        if (funct7 == F7_BASE) begin
          dec.op = {1'b0, funct3};
        end else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec.op = {1'b1, funct3};
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.op0 = rs1_data_i;
        dec.op  = {1'b0, funct3};
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec.op1 = {{(n-5){1'b0}}, inst_i[24:20]};
          if (funct7 == F7_BASE) begin
            bad = 1'b0;
          end else if ((funct3 == 3'b101) && (funct7 == F7_ALT)) begin
            dec.op = OP_SRA;
          end else begin
            bad = 1'b1;
          end
        end else begin
          dec.op1 = {{(n-12){inst_i[31]}}, inst_i[31:20]};
        end
      end
      OPC_LUI: begin
        dec.op1 = {inst_i[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        dec.op0 = pc_i;
        dec.op1 = {inst_i[31:12], 12'h000};
      end
      default: begin
        bad = 1'b1;
      end
    endcase
    if (bad) begin
      dec     = '0;
      dec.ill = 1'b1;
    end else begin
      dec.ill = 1'b0;
    end
  end

  assign accept = inst_valid_i & inst_ready_o;
  assign drain  = main_valid_q & alu_ready_i;

`ifdef ALU_DEC_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   ready_q;

  assign inst_ready_o = ready_q;

  // Main refills from skid first so order is kept; skid only fills while main stalls.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end
`else
  assign inst_ready_o = ~main_valid_q | alu_ready_i;

  // Single register: load on accept, empty on drain without refill.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (accept) begin
      main_d       = dec;
      main_valid_d = 1'b1;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
    end
  end
`endif

  assign operand0_o  = main_q.op0;
  assign operand1_o  = main_q.op1;
  assign alu_op_o    = main_q.op;
  assign rd_addr_o   = main_q.rd;
  assign illegal_o   = main_q.ill;
  assign alu_valid_o = main_valid_q;

endmodule

// File: tb/tb_alu_dec_n.sv
// Scoreboard bench for alu_dec_n: directed vectors, random traffic, back-pressure and reset.
module tb_alu_dec_n;

  typedef struct packed {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

`ifdef ALU_DEC_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] inst_i = 32'h0;
  logic        inst_valid_i = 1'b0;
  logic        inst_ready_o;
  logic [31:0] pc_i = 32'h0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i = 32'h0, rs2_data_i = 32'h0;
  logic [31:0] operand0_o, operand1_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  rd_addr_o;
  logic        illegal_o, alu_valid_o;
  logic        alu_ready_i = 1'b0;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t cur_exp;
  logic last_valid;

  alu_dec_n #(.n(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .operand0_o(operand0_o), .operand1_o(operand1_o), .alu_op_o(alu_op_o),
    .rd_addr_o(rd_addr_o), .illegal_o(illegal_o), .alu_valid_o(alu_valid_o),
    .alu_ready_i(alu_ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: RV32I rules written directly from the ISA field meanings.
  function automatic exp_t ref_model(input logic [31:0] inst, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] pc);
    exp_t e;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    e = '0;
    ok = 1'b1;
    e.rd = inst[11:7];
    case (inst[6:0])
      7'h33: begin
        e.op0 = a;
        e.op1 = b;
        if (f7 == 7'h00) e.op = {1'b0, f3};
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd8;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'hd;
        else ok = 1'b0;
      end
      7'h13: begin
        e.op0 = a;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.op1 = 32'(inst[24:20]);
          if (f7 == 7'h00) e.op = {1'b0, f3};
          else if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'hd;
          else ok = 1'b0;
        end else begin
          e.op1 = 32'(int'($signed(inst[31:20])));
          e.op = {1'b0, f3};
        end
      end
      7'h37: e.op1 = {inst[31:12], 12'h000};
      7'h17: begin
        e.op0 = pc;
        e.op1 = {inst[31:12], 12'h000};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r <= 3) w[6:0] = 7'h33;
    else if (r <= 6) w[6:0] = 7'h13;
    else if (r == 7) w[6:0] = 7'h37;
    else if (r == 8) w[6:0] = 7'h17;
    r = $urandom_range(0, 3);
    if (r == 0) w[31:25] = 7'h00;
    else if (r != 3) w[31:25] = 7'h20;
    return w;
  endfunction

  // One cycle: note the handshake at the falling edge, then move to just after the rising edge.
  task automatic step(output logic acc);
    @(negedge clk);
    acc = inst_valid_i && inst_ready_o && !rst_i;
    if (acc) sb.push_back(cur_exp);
    last_valid = alu_valid_o;
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc);
    inst_i = w;
    rs1_data_i = a;
    rs2_data_i = b;
    pc_i = pc;
    inst_valid_i = 1'b1;
    cur_exp = ref_model(w, a, b, pc);
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input exp_t exp);
    logic acc;
    int t;
    present(w, a, b, pc);
    cur_exp = exp;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 20) begin
      step(acc);
      t++;
    end
    if (!acc) $display("FAIL send_timeout: got no accept expected accept of %h", w);
    inst_valid_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold stability.
  logic hold_pending = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      hold_pending = 1'b0;
    end else begin
      chk("rs1_addr", 32'(rs1_addr_o), 32'(inst_i[19:15]));
      chk("rs2_addr", 32'(rs2_addr_o), 32'(inst_i[24:20]));
      if (hold_pending) begin
        chk("hold_valid", 32'(alu_valid_o), 32'd1);
        chk("hold_stable", 32'({operand0_o, operand1_o, alu_op_o, rd_addr_o, illegal_o} == held), 32'd1);
      end
      if (alu_valid_o && alu_ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("operand0", operand0_o, e.op0);
          chk("operand1", operand1_o, e.op1);
          chk("alu_op", 32'(alu_op_o), 32'(e.op));
          chk("rd_addr", 32'(rd_addr_o), 32'(e.rd));
          chk("illegal", 32'(illegal_o), 32'(e.ill));
        end
      end
      hold_pending = alu_valid_o && !alu_ready_i;
      held = {operand0_o, operand1_o, alu_op_o, rd_addr_o, illegal_o};
    end
  end

  initial begin
    logic acc;
    logic pending;
    int nacc;
    logic [31:0] bp_inst[$];

    // Reset state
    rst_i = 1'b1;
    step(acc);
    step(acc);
    rst_i = 1'b0;
    chk("rst_valid", 32'(alu_valid_o), 32'd0);
    chk("rst_ready", 32'(inst_ready_o), 32'd1);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_operand0", operand0_o, 32'd0);
    chk("rst_operand1", operand1_o, 32'd0);
    chk("rst_op_rd", 32'({alu_op_o, rd_addr_o}), 32'd0);

    // Directed vectors with hand-derived expectations
    alu_ready_i = 1'b1;
    send(32'h002081B3, 32'd5, 32'd7, 32'h0, '{32'd5, 32'd7, 4'd0, 5'd3, 1'b0});
    send(32'h402081B3, 32'd5, 32'd7, 32'h0, '{32'd5, 32'd7, 4'd8, 5'd3, 1'b0});
    send(32'h40335293, 32'h80000000, 32'd9, 32'h0, '{32'h80000000, 32'd3, 4'hd, 5'd5, 1'b0});
    send(32'hFFF00093, 32'h00001234, 32'd0, 32'h0, '{32'h00001234, 32'hFFFFFFFF, 4'd0, 5'd1, 1'b0});
    send(32'h123450B7, 32'hDEADBEEF, 32'd1, 32'h0, '{32'h0, 32'h12345000, 4'd0, 5'd1, 1'b0});
    send(32'h12345097, 32'hDEADBEEF, 32'd1, 32'h100, '{32'h100, 32'h12345000, 4'd0, 5'd1, 1'b0});
    send(32'h0000006F, 32'd3, 32'd4, 32'h40, '{32'h0, 32'h0, 4'd0, 5'd0, 1'b1});
    send(32'h022081B3, 32'd3, 32'd4, 32'h40, '{32'h0, 32'h0, 4'd0, 5'd0, 1'b1});
    send(32'h00000033, 32'd11, 32'd12, 32'h0, '{32'd11, 32'd12, 4'd0, 5'd0, 1'b0});

    // Random traffic with random back-pressure
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      alu_ready_i = ($urandom_range(0, 9) < 7);
      if (!pending && $urandom_range(0, 3) != 0) begin
        present(rand_inst(), $urandom, $urandom, $urandom);
        pending = 1'b1;
      end
      inst_valid_i = pending;
      step(acc);
      if (acc) pending = 1'b0;
    end
    inst_valid_i = 1'b0;
    alu_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) step(acc);
    chk("random_drained", 32'(sb.size()), 32'd0);

    // Back-pressure: A, B, C with the ALU stalled
    alu_ready_i = 1'b0;
    bp_inst = '{32'h00A00093, 32'h00B00113, 32'h00C00193};
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      present(bp_inst[0], 32'd100, 32'd0, 32'h0);
      step(acc);
      if (acc) begin
        void'(bp_inst.pop_front());
        nacc++;
      end
    end
    chk("bp_accepted", 32'(nacc), 32'(CAP));
    chk("bp_ready_low", 32'(inst_ready_o), 32'd0);
    alu_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bp_inst.size() != 0) present(bp_inst[0], 32'd100, 32'd0, 32'h0);
      else inst_valid_i = 1'b0;
      step(acc);
      chk("bp_no_gap", 32'(last_valid), 32'd1);
      if (acc) void'(bp_inst.pop_front());
    end
    inst_valid_i = 1'b0;
    chk("bp_all_sent", 32'(bp_inst.size()), 32'd0);
    step(acc);
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with entries held; none of them may ever appear
    alu_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      present(rand_inst(), $urandom, $urandom, $urandom);
      step(acc);
    end
    rst_i = 1'b1;
    present(32'h00100093, 32'd1, 32'd1, 32'h0);
    step(acc);
    rst_i = 1'b0;
    inst_valid_i = 1'b0;
    sb.delete();
    chk("midrst_valid", 32'(alu_valid_o), 32'd0);
    chk("midrst_ready", 32'(inst_ready_o), 32'd1);
    alu_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(acc);
      chk("midrst_no_output", 32'(last_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
